// File: rtl/mem_responder_if.sv
// Request/response bus between the data-cache initiator (master) and the
// tagged memory responder (slave).
interface mem_responder_if #(
  parameter int XLEN = 32
);
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Tagged fixed-latency memory responder: lowest free tag per request, load data after MEM_LAT.
// Optional macro MEM_RESP_BOUNDS_EN refuses out-of-range addresses and raises a sticky mem_error.
module mem_responder #(
  parameter int XLEN           = 32,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int MEM_LAT        = 8,
  parameter int NUM_TAGS       = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  mem_responder_if.slave            bus,
  input  logic                      init_we,
  input  logic [MEM_DEPTH_BITS-1:0] init_addr,
  input  logic [63:0]               init_data,
  output logic                      mem_error
);

  localparam int         DEPTH     = 1 << MEM_DEPTH_BITS;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [4:0] CNT_INIT  = 5'(MEM_LAT - 1);

  logic [63:0]         r_mem [DEPTH];
  logic [NUM_TAGS:1]   r_busy;
  logic [NUM_TAGS:1]   r_is_store;
  logic [4:0]          r_cnt  [1:NUM_TAGS];
  logic [63:0]         r_slot [1:NUM_TAGS];
  logic [3:0]          r_out_tag;
  logic [63:0]         r_out_data;

  logic [XLEN-1:0]           w_addr;
  logic [MEM_DEPTH_BITS-1:0] w_idx;
  logic                      w_is_load;
  logic                      w_is_store;
  logic                      w_oob;
  logic                      w_unused;
  logic [3:0]                w_free_tag;
  logic [3:0]                w_rsp;
  logic                      w_accept;
  logic [3:0]                w_done_tag;
  logic [63:0]               w_done_data;

  assign w_addr     = bus.proc2mem_addr;
  assign w_idx      = w_addr[MEM_DEPTH_BITS+2:3];
  assign w_is_load  = (bus.proc2mem_command == BUS_LOAD);
  assign w_is_store = (bus.proc2mem_command == BUS_STORE);

`ifdef MEM_RESP_BOUNDS_EN
  assign w_oob    = |w_addr[XLEN-1:MEM_DEPTH_BITS+3];
  assign w_unused = ^w_addr[2:0];
`else
  assign w_oob    = 1'b0;
  assign w_unused = ^{w_addr[XLEN-1:MEM_DEPTH_BITS+3], w_addr[2:0]};
`endif

  always_comb begin
    w_free_tag = '0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!r_busy[t]) w_free_tag = 4'(t);
    end
  end

  assign w_rsp    = ((w_is_load || w_is_store) && !w_oob) ? w_free_tag : 4'd0;
  assign w_accept = (w_rsp != 4'd0);

  // Only one tag can reach count 1 per cycle since only one is accepted per cycle.
  always_comb begin
    w_done_tag  = '0;
    w_done_data = '0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (r_busy[t] && (r_cnt[t] == 5'd1) && !r_is_store[t]) begin
        w_done_tag  = 4'(t);
        w_done_data = r_slot[t];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= '0;
      r_is_store <= '0;
      for (int t = 1; t <= NUM_TAGS; t++) r_cnt[t] <= '0;
      r_out_tag  <= '0;
      r_out_data <= '0;
    end else begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (r_busy[t]) begin
          r_cnt[t] <= r_cnt[t] - 5'd1;
          if (r_cnt[t] == 5'd1) r_busy[t] <= 1'b0;
        end
        if (w_accept && (w_rsp == 4'(t))) begin
          r_busy[t]     <= 1'b1;
          r_cnt[t]      <= CNT_INIT;
          r_is_store[t] <= w_is_store;
        end
      end
      r_out_tag  <= w_done_tag;
      r_out_data <= w_done_data;
    end
  end

  // Load data is snapshotted at accept so later stores cannot disturb it.
  always_ff @(posedge clock) begin
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (w_accept && w_is_load && (w_rsp == 4'(t))) r_slot[t] <= r_mem[w_idx];
    end
  end

  // Bus store issued last so it overrides a backdoor write to the same index.
  always_ff @(posedge clock) begin
    if (init_we) r_mem[init_addr] <= init_data;
    if (w_accept && w_is_store) r_mem[w_idx] <= bus.proc2mem_data;
  end

`ifdef MEM_RESP_BOUNDS_EN
  logic r_mem_error;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_error <= 1'b0;
    end else if ((w_is_load || w_is_store) && w_oob) begin
      r_mem_error <= 1'b1;
    end
  end
  assign mem_error = r_mem_error;
`else
  assign mem_error = 1'b0;
`endif

  assign bus.mem2proc_response = w_rsp;
  assign bus.mem2proc_tag      = r_out_tag;
  assign bus.mem2proc_data     = r_out_data;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable tagged memory responder for the proc2mem / mem2proc bus. It is the memory side that answers the data-cache initiator.
- Each accepted request gets a nonzero response tag in the same cycle. Load data returns a fixed number of cycles later, together with that tag.
- Used as the memory model in cache benches and as the off-core memory stub in full-pipeline simulation.

Parameters:
- XLEN, 32, address width.
- MEM_DEPTH_BITS, 10, log2 of the number of 64-bit doublewords in the backing array (1024 entries = 8 KB).
- MEM_LAT, 8, cycles from request cycle to data/tag cycle; legal range 2..31.
- NUM_TAGS, 15, number of allocatable tags (values 1..NUM_TAGS); legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  0 BUS_NONE, 1 BUS_LOAD, 2 BUS_STORE; 3 is treated as NONE.
- proc2mem_addr  in  XLEN  byte address; bits [2:0] ignored.
- proc2mem_data  in  64  store data (full doubleword).
- init_we  in  1  backdoor preload write enable.
- init_addr  in  MEM_DEPTH_BITS  backdoor doubleword index.
- init_data  in  64  backdoor data.
- mem2proc_response  out  4  tag of the request accepted this cycle; 0 means refused, requester must retry.
- mem2proc_data  out  64  load data, valid while mem2proc_tag != 0.
- mem2proc_tag  out  4  completing load tag; 0 means no completion.
- mem_error  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Interface timing: one clock `clock`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n=0, takes effect immediately):
  - All tags freed; all countdown counters cleared.
  - mem2proc_tag=0, mem2proc_data=0, mem_error=0.
  - Array contents retained.
  - In-flight transactions are dropped and never complete.
- Index: idx = proc2mem_addr[MEM_DEPTH_BITS+2:3]. Upper bits alias unless the optional feature is enabled.
- mem2proc_response is combinational:
  - If command is LOAD or STORE and a free tag exists, it is the lowest-numbered free tag.
  - Otherwise it is 0.
- A request is accepted when mem2proc_response != 0. At the end of the accept cycle:
  - The tag is marked busy and its counter is loaded with MEM_LAT-1.
  - LOAD: array[idx] is snapshotted into the tag's data slot.
  - STORE: array[idx] <= proc2mem_data; the tag's is_store bit is set.
- A refused request (response 0) has no side effects: no write, no allocation.
- Each busy tag's counter decrements every cycle. When it is 1, the tag completes at the next edge:
  - LOAD: the registered outputs mem2proc_tag=tag and mem2proc_data=slot are held for exactly one cycle, which is cycle MEM_LAT counting the request cycle as 0.
  - STORE: no tag is emitted (mem2proc_tag stays 0); the tag is simply freed at the same edge.
  - The tag is freed at the edge that starts its completion cycle, so it is allocatable again in the completion cycle itself.
- At most one acceptance per cycle, so at most one completion per cycle; no completion arbitration is needed.
- Ordering: a load accepted in any cycle after a store's accept cycle observes that store.
- Backdoor port: init_we writes array[init_addr] <= init_data. If a bus STORE to the same index is accepted in the same cycle, the bus store wins.
- Full condition: NUM_TAGS tags busy gives response 0 until a tag frees. Full is reachable only when NUM_TAGS < MEM_LAT.

Optional Feature:
- Macro: MEM_RESP_BOUNDS_EN.
- Defined:
  - A LOAD/STORE whose proc2mem_addr[XLEN-1:MEM_DEPTH_BITS+3] != 0 is refused (response 0, no side effects).
  - mem_error is set at the end of that cycle and stays set until reset.
- Undefined:
  - Upper address bits are ignored (aliasing); such requests are accepted normally.
  - mem_error is tied 0.

Test Plan:
- Preload and load: defaults; init write idx 5 = 64'hDEAD_BEEF_0123_4567; LOAD addr 0x28 in cycle 0 -> response=1 in cycle 0; mem2proc_tag=1 and data=64'hDEAD_BEEF_0123_4567 in cycle 8 only.
- Store then load: STORE addr 0x40 data 64'h1111 in cycle 0 (response=1); LOAD 0x40 in cycle 1 (response=2) -> no tag in cycle 8; tag=2, data=64'h1111 in cycle 9.
- Back-to-back loads: LOADs in cycles 0-3 -> responses 1,2,3,4; completions tags 1,2,3,4 in cycles 8-11 with the matching data.
- Full: NUM_TAGS=4, MEM_LAT=8; LOADs every cycle 0-5 -> responses 1,2,3,4,0,0; tag 1 completes in cycle 8 and a request in cycle 8 receives response 1.
- Reset mid-flight: LOAD in cycle 0, reset_n low in cycle 3 -> outputs 0 immediately; no tag in cycle 8; the next request after reset gets response 1.
- Bounds (MEM_RESP_BOUNDS_EN, MEM_DEPTH_BITS=10): LOAD addr 0x2000 -> response 0, mem_error=1 from the next cycle and sticky; without the macro -> accepted and aliases idx 0.
